// File: rtl/posit_add_arbiter.sv
// Two-requester round-robin front end for a shared combinational posit adder.
// One operation in flight: accept (IDLE) -> capture sum (CALC) -> hold result until taken (DONE).
module posit_add_arbiter #(
  parameter int N  = 32,
  parameter int ES = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [N-1:0]  req0_a,
  input  logic [N-1:0]  req0_b,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [N-1:0]  req1_a,
  input  logic [N-1:0]  req1_b,
  output logic          req1_ready,
  output logic [N-1:0]  add_in1,
  output logic [N-1:0]  add_in2,
  input  logic [N-1:0]  add_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          res_id,
  output logic [CW-1:0] done_cnt0,
  output logic [CW-1:0] done_cnt1
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;
  logic   last_grant, inflight_id;
  logic   grant_vld, grant_id;

  // ES only describes the operand format seen by the external adder.
  logic es_unused;
  assign es_unused = |ES;

  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
          end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
        end
        if (grant_vld) state_nxt = CALC;
      end
      CALC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld &&  grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      inflight_id <= 1'b0;
      add_in1     <= '0;
      add_in2     <= '0;
      res_data    <= '0;
      res_id      <= 1'b0;
      res_valid   <= 1'b0;
      done_cnt0   <= '0;
      done_cnt1   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant_vld) begin
          add_in1     <= grant_id ? req1_a : req0_a;
          add_in2     <= grant_id ? req1_b : req0_b;
          last_grant  <= grant_id;
          inflight_id <= grant_id;
        end
        CALC: begin
          res_data  <= add_out;
          res_id    <= inflight_id;
          res_valid <= 1'b1;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          if (res_id) done_cnt1 <= done_cnt1 + CW'(1);
          else        done_cnt0 <= done_cnt0 + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
